// File: rtl/regfile_pkg.sv
// Shared constants and types for the 8x32 general-purpose register file.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage : regfile_pkg

// File: rtl/register_file_8x32_reg32_en.sv
// One 32-bit storage word: asynchronous clear, loads d on the rising edge when en is high.
module reg32_en
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   // Hold the word, clear it immediately on reset, load it when selected.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : reg32_en

// File: rtl/register_file_8x32.sv
// Eight-entry, 32-bit register file between decode and the ALU.
// One synchronous write port, one combinational read port. Every entry,
// including entry 0, is ordinary storage, and a read of the entry being
// written returns the old value until the write edge.
module register_file_8x32
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wAddr,
   input  logic [DATA_W-1:0] wData,
   input  logic [ADDR_W-1:0] rAddr,
   output logic [DATA_W-1:0] rData
);

   logic [NUM_REGS-1:0] wr_sel;
   word_t               regs [NUM_REGS];

   // One-hot write select, all zero when the write port is idle.
   always_comb begin
      wr_sel = '0;
      if (we) begin
         wr_sel[wAddr] = 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
      reg32_en u_reg (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (wr_sel[i]),
         .d       (wData),
         .q       (regs[i])
      );
   end

   // 8:1 read mux straight from storage; no forwarding from the write port.
   always_comb begin
      rData = regs[rAddr];
   end

endmodule : register_file_8x32

// File: tb/tb_register_file_8x32.sv
// Self-checking bench for register_file_8x32. Expected read values are pushed
// onto a queue when a read is driven and popped when the output is sampled.
module tb_register_file_8x32;

   logic        clk;
   logic        reset_n;
   logic        we;
   logic [2:0]  wAddr;
   logic [31:0] wData;
   logic [2:0]  rAddr;
   logic [31:0] rData;

   logic [31:0] model [8];
   logic [31:0] exp_q [$];
   int          checks;
   int          errors;

   register_file_8x32 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we),
      .wAddr   (wAddr),
      .wData   (wData),
      .rAddr   (rAddr),
      .rData   (rData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drive a read address, push the expected word, sample after settling.
   task automatic read_check(input string tag, input logic [2:0] addr);
      logic [31:0] e;
      rAddr = addr;
      exp_q.push_back(reset_n ? model[addr] : 32'h0);
      #1;
      e = exp_q.pop_front();
      check_eq($sformatf("%s[%0d]", tag, addr), rData, e);
   endtask

   // Present a write (or idle) cycle away from the edge and apply it at the edge.
   task automatic write_cycle(input logic w, input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      we    = w;
      wAddr = a;
      wData = d;
      @(posedge clk);
      if (w && reset_n) model[a] = d;
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) model[i] = 32'h0;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      we      = 1'b1;
      wAddr   = 3'd3;
      wData   = 32'hFFFF_FFFF;
      rAddr   = 3'd0;
      clear_model();

      // Reset held with an active write: nothing may land.
      for (int i = 0; i < 3; i++) write_cycle(1'b1, 3'd3, 32'hFFFF_FFFF);
      @(negedge clk);
      for (int a = 0; a < 8; a++) read_check("reset", 3'(a));

      // Release reset away from the edge, then fill entries 1..7.
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k < 8; k++) write_cycle(1'b1, 3'(k), 32'(k));
      @(negedge clk);
      we = 1'b0;
      for (int a = 0; a < 8; a++) read_check("fill", 3'(a));

      // Write disabled must not modify anything.
      for (int i = 0; i < 3; i++) write_cycle(1'b0, 3'd2, 32'hDEAD_BEEF);
      @(negedge clk);
      read_check("wedis", 3'd2);

      // Entry 0 writable, entry 7 overwritten, others unchanged.
      write_cycle(1'b1, 3'd0, 32'hA5A5_A5A5);
      write_cycle(1'b1, 3'd7, 32'h1234_5678);
      @(negedge clk);
      we = 1'b0;
      check_eq("model0", model[0], 32'hA5A5_A5A5);
      for (int a = 0; a < 8; a++) read_check("ovr", 3'(a));

      // Read-during-write: old value before the edge, new value after it.
      @(negedge clk);
      we    = 1'b1;
      wAddr = 3'd4;
      wData = 32'hCAFE_0004;
      read_check("rdw_pre", 3'd4);
      check_eq("rdw_old", rData, 32'h0000_0004);
      @(posedge clk);
      model[4] = 32'hCAFE_0004;
      #1;
      read_check("rdw_post", 3'd4);
      @(negedge clk);
      we = 1'b0;

      // Asynchronous reset between edges clears without a clock edge.
      rAddr = 3'd7;
      #2;
      check_eq("pre_async", rData, 32'h1234_5678);
      reset_n = 1'b0;
      #1;
      check_eq("async_drop", rData, 32'h0);
      #1;
      reset_n = 1'b1;
      clear_model();
      for (int a = 0; a < 8; a++) read_check("post_rst", 3'(a));

      // First write after reset release lands on the first edge.
      write_cycle(1'b1, 3'd5, 32'h5555_0005);
      @(negedge clk);
      we = 1'b0;
      read_check("after_rst_wr", 3'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_register_file_8x32
